// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback arbiter and its EX-request buffer.
package wb_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int XLEN          = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       pc;
        logic                  isCall;
    } wb_ex_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } wb_occ_e;

    // Occupancy step: a simultaneous push and pop leaves the level unchanged.
    function automatic wb_occ_e occ_next(input wb_occ_e s, input logic push, input logic pop);
        wb_occ_e n;
        n = s;
        if (push && !pop) begin
            case (s)
                OCC_EMPTY: n = OCC_ONE;
                default:   n = OCC_FULL;
            endcase
        end else if (pop && !push) begin
            case (s)
                OCC_FULL: n = OCC_ONE;
                default:  n = OCC_EMPTY;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for accepted EX writeback requests; supports push and pop
// in the same cycle. The caller must never push while full or pop while empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    input  wb_ex_t din,
    output wb_ex_t dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_ex_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback slot arbiter: loads first, then buffered EX requests, then a same-cycle
// EX request. Optional bypass outputs are built when WB_BYPASS_EN is defined.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_alu,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic                  ex_isCall,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_a,
    output logic [XLEN-1:0]       wb_l,
    output logic [XLEN-1:0]       wb_p,
    output logic                  wb_isLd,
    output logic                  wb_isCall,
    output logic [1:0]            dbg_state_o
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_rd,
    output logic [XLEN-1:0]       byp_data
`endif
);

    wb_occ_e state_q;
    wb_ex_t  ex_req;
    wb_ex_t  head;
    wb_ex_t  gnt;
    logic    fifo_full;
    logic    fifo_empty;
    logic    ex_acc;
    logic    push;
    logic    pop;
    logic    grant_ld;
    logic    grant_ex;

    // Handshake: an EX request transfers on a cycle where ex_valid and ex_ready are both
    // high; ex_ready depends only on occupancy, never on ex_valid or ld_valid.
    assign ex_ready    = !fifo_full;
    assign ex_acc      = ex_valid && ex_ready;
    assign dbg_state_o = state_q;

    always_comb begin
        ex_req.rd     = ex_rd;
        ex_req.alu    = ex_alu;
        ex_req.pc     = ex_pc;
        ex_req.isCall = ex_isCall;
    end

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        grant_ld = 1'b0;
        grant_ex = 1'b0;
        gnt      = ex_req;
        if (ld_valid) begin
            grant_ld = 1'b1;
            push     = ex_acc;
        end else if (!fifo_empty) begin
            grant_ex = 1'b1;
            gnt      = head;
            pop      = 1'b1;
            push     = ex_acc;
        end else if (ex_acc) begin
            // Empty buffer and free slot: issue straight through without buffering.
            grant_ex = 1'b1;
        end
    end

    wb_fifo #(
        .DEPTH(WB_FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .full (fifo_full),
        .empty(fifo_empty),
        .din  (ex_req),
        .dout (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_a      <= '0;
            wb_l      <= '0;
            wb_p      <= '0;
            wb_isLd   <= 1'b0;
            wb_isCall <= 1'b0;
        end else begin
            state_q   <= occ_next(state_q, push, pop);
            wb_we     <= 1'b0;
            wb_isLd   <= 1'b0;
            wb_isCall <= 1'b0;
            if (grant_ld) begin
                wb_we   <= (ld_rd != '0);
                wb_rd   <= ld_rd;
                wb_l    <= ld_data;
                wb_isLd <= 1'b1;
            end else if (grant_ex) begin
                wb_we     <= (gnt.rd != '0);
                wb_rd     <= gnt.rd;
                wb_a      <= gnt.alu;
                wb_p      <= gnt.pc;
                wb_isCall <= gnt.isCall;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = wb_we;
    assign byp_rd    = wb_rd;
    assign byp_data  = wb_isCall ? wb_p : (wb_isLd ? wb_l : wb_a);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_isCall, ld_valid;
    logic [4:0]  ex_rd, ld_rd, wb_rd;
    logic [31:0] ex_alu, ex_pc, ld_data, wb_a, wb_l, wb_p;
    logic        wb_we, wb_isLd, wb_isCall;
    logic [1:0]  dbg_state;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
`endif

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_alu(ex_alu),
        .ex_pc(ex_pc), .ex_isCall(ex_isCall),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_a(wb_a), .wb_l(wb_l), .wb_p(wb_p),
        .wb_isLd(wb_isLd), .wb_isCall(wb_isCall), .dbg_state_o(dbg_state)
`ifdef WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
    );

    // Reference model: pending EX entries packed {rd, alu, pc, isCall}, plus expected outputs.
    logic [69:0] exp_q[$];
    logic        e_we, e_isld, e_call;
    logic [4:0]  e_rd;
    logic [31:0] e_a, e_l, e_p;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        e_we = 0; e_isld = 0; e_call = 0; e_rd = '0; e_a = '0; e_l = '0; e_p = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".we"},   32'(wb_we),     32'(e_we));
        chk({tag, ".rd"},   32'(wb_rd),     32'(e_rd));
        chk({tag, ".a"},    wb_a,           e_a);
        chk({tag, ".l"},    wb_l,           e_l);
        chk({tag, ".p"},    wb_p,           e_p);
        chk({tag, ".isLd"}, 32'(wb_isLd),   32'(e_isld));
        chk({tag, ".call"}, 32'(wb_isCall), 32'(e_call));
        chk({tag, ".occ"},  32'(dbg_state), exp_q.size());
`ifdef WB_BYPASS_EN
        chk({tag, ".byp_valid"}, 32'(byp_valid), 32'(e_we));
        chk({tag, ".byp_rd"},    32'(byp_rd),    32'(e_rd));
        chk({tag, ".byp_data"},  byp_data, e_call ? e_p : (e_isld ? e_l : e_a));
`endif
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, ".we"},    32'(wb_we),     0);
        chk({tag, ".rd"},    32'(wb_rd),     0);
        chk({tag, ".a"},     wb_a,           0);
        chk({tag, ".l"},     wb_l,           0);
        chk({tag, ".p"},     wb_p,           0);
        chk({tag, ".isLd"},  32'(wb_isLd),   0);
        chk({tag, ".call"},  32'(wb_isCall), 0);
        chk({tag, ".ready"}, 32'(ex_ready),  1);
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic ev, input logic [4:0] erd, input logic [31:0] ealu,
                        input logic [31:0] epc, input logic ecall, input string tag);
        logic        rdy, acc, gex;
        logic [69:0] ent, g;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        ex_valid = ev; ex_rd = erd; ex_alu = ealu; ex_pc = epc; ex_isCall = ecall;
        rdy = (exp_q.size() < 2);
        acc = ev && rdy;
        ent = {erd, ealu, epc, ecall};
        g   = '0;
        gex = 1'b0;
        #3;
        chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(rdy));
        if (ev && ex_ready) hs_cnt++;
        if (lv) begin
            e_we = (lrd != 0); e_rd = lrd; e_l = ldat; e_isld = 1; e_call = 0;
        end else if (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            gex = 1;
        end else if (acc) begin
            g = ent;
            gex = 1;
            acc = 0;
        end
        if (acc) exp_q.push_back(ent);
        if (gex) begin
            e_rd = g[69:65]; e_a = g[64:33]; e_p = g[32:1]; e_call = g[0];
            e_we = (g[69:65] != 0); e_isld = 0;
        end else if (!lv) begin
            e_we = 0; e_isld = 0; e_call = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst_n = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        ex_valid = 0; ex_rd = 0; ex_alu = 0; ex_pc = 0; ex_isCall = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("reset");
        rst_n = 1;

        // Single EX request straight through an empty buffer.
        step(0, 0, 0, 1, 5'd3, 32'h10, 32'h0, 0, "single_ex");
        chk("single_ex.we_const", 32'(wb_we), 1);
        chk("single_ex.rd_const", 32'(wb_rd), 3);
        chk("single_ex.a_const",  wb_a, 32'h10);
        chk("single_ex.isLd_const", 32'(wb_isLd), 0);
        idle("idle0");

        // Load and EX together: load wins, EX follows from the buffer.
        step(1, 5'd5, 32'hAAAA_5555, 1, 5'd6, 32'h66, 32'h0, 0, "ld_ex_c1");
        chk("ld_ex_c1.rd_const", 32'(wb_rd), 5);
        chk("ld_ex_c1.isLd_const", 32'(wb_isLd), 1);
        idle("ld_ex_c2");
        chk("ld_ex_c2.rd_const", 32'(wb_rd), 6);
        chk("ld_ex_c2.we_const", 32'(wb_we), 1);

        // Four back-to-back loads against a held EX stream: only two get buffered.
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 5'(20 + i), 32'h1000 + i, 1, 5'(10 + hs_cnt), 32'hA0 + hs_cnt,
                 32'h200, 0, "ld_stream");
        end
        chk("ld_stream.accepts", hs_cnt, 2);
        chk("ld_stream.occ_full", 32'(dbg_state), 2);
        idle("drain1");
        chk("drain1.rd_const", 32'(wb_rd), 10);
        idle("drain2");
        chk("drain2.rd_const", 32'(wb_rd), 11);
        idle("drain3");

        // Call requests, with and without a destination register.
        step(0, 0, 0, 1, 5'd1, 32'h55, 32'h104, 1, "call_rd1");
        chk("call_rd1.call_const", 32'(wb_isCall), 1);
        chk("call_rd1.p_const", wb_p, 32'h104);
        chk("call_rd1.we_const", 32'(wb_we), 1);
        step(0, 0, 0, 1, 5'd0, 32'h55, 32'h104, 1, "call_rd0");
        chk("call_rd0.we_const", 32'(wb_we), 0);

        // Reset asserted mid-cycle with the buffer full.
        step(1, 5'd8, 32'h8, 1, 5'd14, 32'hE, 32'h0, 0, "fill1");
        step(1, 5'd9, 32'h9, 1, 5'd15, 32'hF, 32'h0, 0, "fill2");
        chk("fill2.occ_full", 32'(dbg_state), 2);
        #2;
        rst_n = 0;
        ld_valid = 0; ex_valid = 0;
        #1;
        check_reset_zero("mid_reset");
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle("post_reset1");
        chk("post_reset1.ready_const", 32'(ex_ready), 1);
        idle("post_reset2");

        // Load of 0xDEAD to r7, visible on the bypass in the same cycle as wb_we.
        step(1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, "ld_dead");
`ifdef WB_BYPASS_EN
        chk("ld_dead.byp_valid_const", 32'(byp_valid), 1);
        chk("ld_dead.byp_rd_const", 32'(byp_rd), 7);
        chk("ld_dead.byp_data_const", byp_data, 32'hDEAD);
`endif
        idle("idle1");

        for (int i = 0; i < 400; i++) begin
            logic [4:0] lr, er;
            lr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            er = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(($urandom_range(0, 9) < 4), lr, $urandom,
                 ($urandom_range(0, 9) < 6), er, $urandom, $urandom,
                 $urandom_range(0, 1) == 1, "rand");
        end
        repeat (3) idle("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: ex_valid in 1, ex_ready out 1: EX-path writeback request handshake.
REQ-003 SHALL have ports: ex_rd in 5 (dest reg), ex_alu in 32 (ALU result), ex_pc in 32 (return address), ex_isCall in 1 (call).
REQ-004 SHALL have ports: ld_valid in 1 (load return, cannot be back-pressured), ld_rd in 5, ld_data in 32.
REQ-005 SHALL have ports, all registered, driving the writeback mux and register file: wb_we out 1, wb_rd out 5, wb_a out 32, wb_l out 32, wb_p out 32, wb_isLd out 1, wb_isCall out 1.

Function
REQ-006 SHALL accept an EX request on the cycle where ex_valid && ex_ready are both high.
REQ-007 SHALL buffer accepted EX requests in a 2-entry in-order FIFO; ex_ready = (count < 2).
REQ-008 SHALL track FIFO occupancy as states EMPTY/ONE/FULL; push only -> up one state; pop only -> down one; push and pop together -> state unchanged.
REQ-009 SHALL grant the single write slot each cycle by fixed priority: ld_valid first, then FIFO head, then a same-cycle EX request.
REQ-010 SHALL, when the FIFO is EMPTY, ld_valid=0 and an EX request is accepted, issue that request directly without writing it into the FIFO.
REQ-011 SHALL register the granted request: outputs update on the clock edge after the grant (latency 1 cycle).
REQ-012 SHALL, on a load grant, drive wb_isLd=1, wb_isCall=0, wb_l=ld_data, wb_rd=ld_rd.
REQ-013 SHALL, on an EX grant, drive wb_isLd=0, wb_isCall=ex_isCall, wb_a=ex_alu, wb_p=ex_pc, wb_rd=ex_rd.
REQ-014 SHALL drive wb_we=1 only for a granted request with rd != 0; rd==0 grants give wb_we=0 and still consume the slot.
REQ-015 SHALL, when nothing is granted, drive wb_we=0, wb_isLd=0 and wb_isCall=0, and hold the data and rd outputs.
REQ-016 SHALL retire EX requests in acceptance order; a load may overtake buffered EX entries.
REQ-017 SHALL, with ld_valid high and the FIFO FULL, hold ex_ready=0 and leave FIFO contents intact; no request is ever dropped.

Reset
REQ-018 SHALL, while rst_n=0, clear wb_we, wb_isLd and wb_isCall to 0, wb_rd to 0, wb_a/wb_l/wb_p to 0, and FIFO occupancy to EMPTY.
REQ-019 SHALL, on reset assertion mid-operation, discard buffered entries immediately; ex_ready=1 from the first cycle after deassertion.

Configuration
REQ-020 SHALL, when WB_BYPASS_EN is defined, add outputs byp_valid (1), byp_rd (5) and byp_data (32), driven combinationally from the registered wb_* signals: byp_valid=wb_we, byp_rd=wb_rd, byp_data = wb_p if wb_isCall, else wb_l if wb_isLd, else wb_a.
REQ-021 SHALL, when WB_BYPASS_EN is undefined, omit the byp_* ports and logic entirely.

Structure
REQ-022 SHALL place REG_ADDR_W=5, XLEN=32, WB_FIFO_DEPTH=2 and the EX-entry struct {rd, alu, pc, isCall} in shared package wb_pkg.
REQ-023 SHALL implement the buffer as sub-module wb_fifo (parameterised depth; ports: push, pop, full, empty, din, dout).

Verification
REQ-024 Single EX request, rd=3, alu=0x10, FIFO EMPTY, no load -> next cycle wb_we=1, wb_rd=3, wb_a=0x10, wb_isLd=0.
REQ-025 ld_valid and ex_valid in the same cycle (ld_rd=5, ex_rd=6) -> cycle+1 writes r5 with wb_isLd=1; cycle+2 writes r6 from the FIFO.
REQ-026 ld_valid held 4 cycles while ex_valid held -> exactly 2 EX accepts, then ex_ready=0; after the loads stop, the 2 EX writes drain in order.
REQ-027 Call request, isCall=1, pc=0x104, rd=1 -> wb_isCall=1, wb_p=0x104, wb_we=1; the same request with rd=0 -> wb_we=0.
REQ-028 rst_n pulsed low with the FIFO FULL -> all outputs 0 asynchronously; after release ex_ready=1 and no stale write occurs.
REQ-029 With WB_BYPASS_EN defined, a load write of 0xDEAD to r7 -> byp_valid=1, byp_rd=7, byp_data=0xDEAD in the same cycle as wb_we.
